// File: rtl/reg_file_rename.sv
// reg_file_rename
//   Architectural register file with a rename-tag table. It is written by the ROB
//   commit port and read by the dispatcher.
//   Each register holds a value (val) and a tag (tag). The tag names the in-flight
//   ROB entry that will produce the register's next value; tag 0 means the value is
//   final. Register x0 always reads as zero and never holds a tag.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     rdy               global enable; when low, all state holds
//     rollback_signal   mispredict flush; clears every tag
//     res_rdy_from_rob  commit valid, with regidx/res/alias_from_rob
//     rename_ena        dispatcher rename of rename_rd to rename_alias
//     rs1_idx, rs2_idx  source queries
//     Qi/Qj_2dsp        owner tag of rs1/rs2 (0 when the value is final)
//     Vi/Vj_2dsp        value of rs1/rs2
module reg_file_rename #(
  parameter int REG_NUM   = 32,
  parameter int REG_IDX_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_ID_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback_signal,
  input  logic                 res_rdy_from_rob,
  input  logic [REG_IDX_W-1:0] regidx_from_rob,
  input  logic [DATA_W-1:0]    res_from_rob,
  input  logic [ROB_ID_W-1:0]  alias_from_rob,
  input  logic                 rename_ena,
  input  logic [REG_IDX_W-1:0] rename_rd,
  input  logic [ROB_ID_W-1:0]  rename_alias,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [ROB_ID_W-1:0]  Qi_2dsp,
  output logic [ROB_ID_W-1:0]  Qj_2dsp,
  output logic [DATA_W-1:0]    Vi_2dsp,
  output logic [DATA_W-1:0]    Vj_2dsp
);

  localparam logic [REG_IDX_W-1:0] X0     = {REG_IDX_W{1'b0}};
  localparam logic [ROB_ID_W-1:0]  NO_TAG = {ROB_ID_W{1'b0}};
  localparam logic [DATA_W-1:0]    ZERO_V = {DATA_W{1'b0}};

  logic [DATA_W-1:0]   val_r [REG_NUM];
  logic [ROB_ID_W-1:0] tag_r [REG_NUM];

  logic commit_s;
  logic rename_s;

  // Qualify commit and rename; writes aimed at x0 are dropped here.
  always_comb begin
    commit_s = res_rdy_from_rob && (regidx_from_rob != X0);
    rename_s = rename_ena && (rename_rd != X0);
  end

  // Register value and tag state update; priority is rst, hold, rollback, then normal.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_r[i] <= ZERO_V;
        tag_r[i] <= NO_TAG;
      end
    end else if (rdy) begin
      // A commit always lands in val, including during a rollback cycle.
      if (commit_s) begin
        val_r[regidx_from_rob] <= res_from_rob;
      end
      if (rollback_signal) begin
        // Every in-flight owner is squashed. A rename in this cycle belongs to a
        // squashed instruction, so it is ignored.
        for (int i = 0; i < REG_NUM; i++) begin
          tag_r[i] <= NO_TAG;
        end
      end else begin
        // Free the tag only if the committing entry is still the newest owner.
        if (commit_s && (tag_r[regidx_from_rob] == alias_from_rob)) begin
          tag_r[regidx_from_rob] <= NO_TAG;
        end
        // This assignment comes last, so a same-register rename overrides the
        // commit's tag release.
        if (rename_s) begin
          tag_r[rename_rd] <= rename_alias;
        end
      end
    end
  end

  // rs1 resolution. A same-cycle commit by the current owner is forwarded as a final value.
  always_comb begin
    Qi_2dsp = NO_TAG;
    Vi_2dsp = ZERO_V;
    if (rs1_idx == X0) begin
      Qi_2dsp = NO_TAG;
      Vi_2dsp = ZERO_V;
    end else if ((tag_r[rs1_idx] != NO_TAG) && res_rdy_from_rob &&
                 (regidx_from_rob == rs1_idx) && (alias_from_rob == tag_r[rs1_idx])) begin
      Qi_2dsp = NO_TAG;
      Vi_2dsp = res_from_rob;
    end else begin
      Qi_2dsp = tag_r[rs1_idx];
      Vi_2dsp = val_r[rs1_idx];
    end
  end

  // rs2 resolution. Same forwarding rule as rs1.
  always_comb begin
    Qj_2dsp = NO_TAG;
    Vj_2dsp = ZERO_V;
    if (rs2_idx == X0) begin
      Qj_2dsp = NO_TAG;
      Vj_2dsp = ZERO_V;
    end else if ((tag_r[rs2_idx] != NO_TAG) && res_rdy_from_rob &&
                 (regidx_from_rob == rs2_idx) && (alias_from_rob == tag_r[rs2_idx])) begin
      Qj_2dsp = NO_TAG;
      Vj_2dsp = res_from_rob;
    end else begin
      Qj_2dsp = tag_r[rs2_idx];
      Vj_2dsp = val_r[rs2_idx];
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename
//   Directed scenarios followed by randomized traffic. The outputs are compared
//   against a reference register/tag model that is kept in plain arrays.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback_signal;
  logic        res_rdy_from_rob;
  logic [4:0]  regidx_from_rob;
  logic [31:0] res_from_rob;
  logic [3:0]  alias_from_rob;
  logic        rename_ena;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_alias;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [3:0]  Qi_2dsp, Qj_2dsp;
  logic [31:0] Vi_2dsp, Vj_2dsp;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mval [32];
  logic [3:0]  mtag [32];

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
    .res_rdy_from_rob(res_rdy_from_rob), .regidx_from_rob(regidx_from_rob),
    .res_from_rob(res_from_rob), .alias_from_rob(alias_from_rob),
    .rename_ena(rename_ena), .rename_rd(rename_rd), .rename_alias(rename_alias),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .Qi_2dsp(Qi_2dsp), .Qj_2dsp(Qj_2dsp), .Vi_2dsp(Vi_2dsp), .Vj_2dsp(Vj_2dsp)
  );

  always #5 clk = ~clk;

  // Tag the dispatcher should see for source register rs under the current inputs.
  function automatic logic [3:0] exp_q(input logic [4:0] rs);
    if (rs == 5'd0) return 4'd0;
    if (mtag[rs] != 4'd0 && res_rdy_from_rob && regidx_from_rob == rs && alias_from_rob == mtag[rs])
      return 4'd0;
    return mtag[rs];
  endfunction

  // Value the dispatcher should see for source register rs under the current inputs.
  function automatic logic [31:0] exp_v(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (mtag[rs] != 4'd0 && res_rdy_from_rob && regidx_from_rob == rs && alias_from_rob == mtag[rs])
      return res_from_rob;
    return mval[rs];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic chk_model(input string name);
    #2;
    chk({name, ".Qi"}, {28'd0, Qi_2dsp}, {28'd0, exp_q(rs1_idx)});
    chk({name, ".Vi"}, Vi_2dsp, exp_v(rs1_idx));
    chk({name, ".Qj"}, {28'd0, Qj_2dsp}, {28'd0, exp_q(rs2_idx)});
    chk({name, ".Vj"}, Vj_2dsp, exp_v(rs2_idx));
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    logic [3:0] old_tag;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mval[i] = 32'd0; mtag[i] = 4'd0; end
    end else if (rdy) begin
      old_tag = mtag[regidx_from_rob];
      if (res_rdy_from_rob && regidx_from_rob != 5'd0) mval[regidx_from_rob] = res_from_rob;
      if (rollback_signal) begin
        for (int i = 0; i < 32; i++) mtag[i] = 4'd0;
      end else begin
        if (res_rdy_from_rob && regidx_from_rob != 5'd0 && old_tag == alias_from_rob)
          mtag[regidx_from_rob] = 4'd0;
        if (rename_ena && rename_rd != 5'd0) mtag[rename_rd] = rename_alias;
      end
    end
    #1;
  endtask

  task automatic drive(input logic rb, input logic cv, input logic [4:0] cr, input logic [31:0] cd,
                       input logic [3:0] ca, input logic re, input logic [4:0] rr,
                       input logic [3:0] ra, input logic [4:0] q1, input logic [4:0] q2);
    rollback_signal  = rb;
    res_rdy_from_rob = cv; regidx_from_rob = cr; res_from_rob = cd; alias_from_rob = ca;
    rename_ena       = re; rename_rd = rr; rename_alias = ra;
    rs1_idx = q1; rs2_idx = q2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mval[i] = 32'd0; mtag[i] = 4'd0; end
    rst = 1'b1; rdy = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd0, 5'd0);
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd5, 5'd0);
    chk_model("reset");
    chk("reset.Qi_lit", {28'd0, Qi_2dsp}, 32'd0);
    chk("reset.Vi_lit", Vi_2dsp, 32'd0);

    // Rename, then commit with same-cycle bypass
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd3, 4'd4, 5'd3, 5'd0);
    chk_model("ren_x3");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd3, 5'd0);
    chk_model("x3_tagged");
    chk("x3_tagged.Qi_lit", {28'd0, Qi_2dsp}, 32'd4);
    drive(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 4'd4, 1'b0, 5'd0, 4'd0, 5'd3, 5'd3);
    chk_model("x3_bypass");
    chk("x3_bypass.Vi_lit", Vi_2dsp, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd3, 5'd0);
    chk_model("x3_done");
    chk("x3_done.Qi_lit", {28'd0, Qi_2dsp}, 32'd0);
    chk("x3_done.Vi_lit", Vi_2dsp, 32'hDEADBEEF);

    // Stale commit keeps the newer owner
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 4'd2, 5'd7, 5'd0); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 4'd6, 5'd7, 5'd0); tick();
    drive(1'b0, 1'b1, 5'd7, 32'h11, 4'd2, 1'b0, 5'd0, 4'd0, 5'd7, 5'd0);
    chk_model("x7_stale");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd7, 5'd0);
    chk_model("x7_after");
    chk("x7_after.Qi_lit", {28'd0, Qi_2dsp}, 32'd6);
    chk("x7_after.Vi_lit", Vi_2dsp, 32'h11);

    // Commit and rename of the same register in one cycle
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd9, 4'd3, 5'd9, 5'd0); tick();
    drive(1'b0, 1'b1, 5'd9, 32'h55, 4'd3, 1'b1, 5'd9, 4'd8, 5'd9, 5'd0);
    chk_model("x9_same");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd9, 5'd9);
    chk_model("x9_after");
    chk("x9_after.Qi_lit", {28'd0, Qi_2dsp}, 32'd8);
    chk("x9_after.Vi_lit", Vi_2dsp, 32'h55);

    // Rollback: all tags cleared, the commit still writes, the rename is ignored
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd1, 4'd1, 5'd0, 5'd0); tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd2, 4'd2, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd1, 32'h99, 4'd1, 1'b1, 5'd4, 4'd5, 5'd2, 5'd4);
    chk_model("rollback_cyc");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd1, 5'd4);
    chk_model("rb_x1_x4");
    chk("rb.Vi_lit", Vi_2dsp, 32'h99);
    chk("rb.Qj_lit", {28'd0, Qj_2dsp}, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd9, 5'd7);
    chk_model("rb_x9_x7");

    // x0 is immune to commits and renames
    drive(1'b0, 1'b1, 5'd0, 32'h123, 4'd3, 1'b1, 5'd0, 4'd3, 5'd0, 5'd0);
    chk_model("x0_wr");
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd0, 5'd0);
    chk_model("x0_after");

    // rdy low holds state; the bypass stays visible
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd7, 5'd5, 5'd0); tick();
    rdy = 1'b0;
    drive(1'b0, 1'b1, 5'd5, 32'hAB, 4'd7, 1'b1, 5'd6, 4'd9, 5'd5, 5'd6);
    chk_model("hold_bypass");
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd5, 5'd6);
    tick();
    rdy = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 5'd5, 5'd6);
    chk_model("hold_after");
    chk("hold.Qi_lit", {28'd0, Qi_2dsp}, 32'd7);
    chk("hold.Vi_lit", Vi_2dsp, 32'd0);

    // Randomized traffic on a small register window, so collisions are frequent
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      // Sometimes aim the commit at the current owner so the bypass path is exercised.
      if ($urandom_range(0, 1) == 1 && mtag[regidx_from_rob] != 4'd0)
        alias_from_rob = mtag[regidx_from_rob];
      chk_model("random");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
